// File: rtl/dec_strobe_gen.sv
// dec_strobe_gen: registered enable-gated one-hot strobe decoder with level, pulse and scan modes
module dec_strobe_gen #(
    parameter int SEL_W      = 3,
    parameter int DWELL_W    = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_g1_i,
    input  logic                  en_g2a_n_i,
    input  logic                  en_g2b_n_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic [1:0]            mode_i,
    input  logic                  req_i,
    input  logic [DWELL_W-1:0]    dwell_i,
    output logic [(1<<SEL_W)-1:0] out_o,
    output logic                  busy_o,
    output logic [SEL_W-1:0]      idx_o
);
    localparam int NOUT = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_SCAN} state_t;

    state_t             state_q, state_d;
    logic [NOUT-1:0]    out_q, out_d, onehot;
    logic               busy_q, busy_d;
    logic [SEL_W-1:0]   idx_q, idx_d, line;
    logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
    logic               req_q, armed_q, act, en_ok, req_rise;

    assign en_ok    = en_g1_i & ~en_g2a_n_i & ~en_g2b_n_i;
    // armed_q blocks a req that was already high through reset until it has been seen low
    assign req_rise = req_i & ~req_q & armed_q;
    assign out_o    = out_q;
    assign busy_o   = busy_q;
    assign idx_o    = idx_q;

    // next state: choose which line (if any) is asserted next cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        act     = 1'b0;
        line    = '0;
        case (state_q)
            S_IDLE: begin
                if (en_ok && mode_i == 2'b00) begin
                    act  = 1'b1;
                    line = sel_i;
                end else if (en_ok && req_rise && mode_i == 2'b01) begin
                    state_d = S_PULSE;
                    act     = 1'b1;
                    line    = sel_i;
                end else if (en_ok && req_rise && mode_i == 2'b10) begin
                    state_d = S_SCAN;
                    act     = 1'b1;
                    dwell_d = dwell_i;
                    cnt_d   = dwell_i;
                end
            end
            S_PULSE: state_d = S_IDLE;
            S_SCAN: begin
                if (!en_ok) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    act   = 1'b1;
                    line  = idx_q;
                end else if (idx_q == LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = dwell_q;
                    act   = 1'b1;
                    line  = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        onehot = act ? (NOUT'(1) << line) : '0;
        out_d  = ACTIVE_LOW ? ~onehot : onehot;
        idx_d  = act ? line : '0;
        busy_d = state_d != S_IDLE;
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= {NOUT{ACTIVE_LOW}};
            busy_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            req_q   <= 1'b0;
            armed_q <= ~req_i;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            req_q   <= req_i;
            armed_q <= armed_q | ~req_i;
        end
    end
endmodule

// File: tb/tb_dec_strobe_gen.sv
// tb_dec_strobe_gen: directed self-checking bench for dec_strobe_gen
module tb_dec_strobe_gen;
    logic clk = 1'b0, rst = 1'b1;
    logic g1 = 1'b1, g2a = 1'b0, g2b = 1'b0, req = 1'b0;
    logic [2:0] sel = '0;
    logic [1:0] mode = '0;
    logic [7:0] dwell = '0;
    logic [7:0] out;
    logic busy;
    logic [2:0] idx;
    logic g1b = 1'b0;
    logic [3:0] sel2 = '0;
    logic [15:0] out2;
    logic busy2;
    logic [3:0] idx2;
    int n = 0, errs = 0;

    dec_strobe_gen u_dut (
        .clk(clk), .rst(rst), .en_g1_i(g1), .en_g2a_n_i(g2a), .en_g2b_n_i(g2b),
        .sel_i(sel), .mode_i(mode), .req_i(req), .dwell_i(dwell),
        .out_o(out), .busy_o(busy), .idx_o(idx)
    );

    dec_strobe_gen #(.SEL_W(4), .DWELL_W(8), .ACTIVE_LOW(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .en_g1_i(g1b), .en_g2a_n_i(1'b0), .en_g2b_n_i(1'b0),
        .sel_i(sel2), .mode_i(2'b00), .req_i(1'b0), .dwell_i(8'd0),
        .out_o(out2), .busy_o(busy2), .idx_o(idx2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [7:0] eo, input logic eb, input logic [2:0] ei);
        chk({tag, ".out"}, 32'(out), 32'(eo));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".idx"}, 32'(idx), 32'(ei));
    endtask

    initial begin
        logic [7:0] e;
        step();
        step();
        chk3("reset", 8'hFF, 1'b0, 3'd0);
        chk("reset.out2", 32'(out2), 32'h0);
        rst = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step();
            e = 8'hFF ^ (8'd1 << s);
            chk3($sformatf("level%0d", s), e, 1'b0, 3'(s));
        end
        g2a = 1'b1;
        step();
        chk3("level_g2a_off", 8'hFF, 1'b0, 3'd0);
        g2a = 1'b0;
        g2b = 1'b1;
        sel = 3'd2;
        step();
        chk3("level_g2b_off", 8'hFF, 1'b0, 3'd0);
        g2b = 1'b0;

        mode = 2'b01;
        sel = 3'd5;
        step();
        chk3("pulse_wait", 8'hFF, 1'b0, 3'd0);
        req = 1'b1;
        step();
        chk3("pulse_on", 8'hDF, 1'b1, 3'd5);
        step();
        chk3("pulse_off1", 8'hFF, 1'b0, 3'd0);
        step();
        chk3("pulse_off2", 8'hFF, 1'b0, 3'd0);
        step();
        chk3("pulse_off3", 8'hFF, 1'b0, 3'd0);
        req = 1'b0;
        step();
        chk3("pulse_off4", 8'hFF, 1'b0, 3'd0);

        mode = 2'b10;
        dwell = 8'd2;
        req = 1'b1;
        step();
        req = 1'b0;
        dwell = 8'd5;
        mode = 2'b00;
        sel = 3'd7;
        chk3("scan0", 8'hFE, 1'b1, 3'd0);
        for (int c = 1; c < 24; c++) begin
            req = (c == 10);
            step();
            e = 8'hFF ^ (8'd1 << (c / 3));
            chk3($sformatf("scan%0d", c), e, 1'b1, 3'(c / 3));
        end
        req = 1'b0;
        mode = 2'b10;
        step();
        chk3("scan_end", 8'hFF, 1'b0, 3'd0);
        step();
        chk3("scan_idle", 8'hFF, 1'b0, 3'd0);

        dwell = 8'd0;
        req = 1'b1;
        step();
        req = 1'b0;
        chk3("abort0", 8'hFE, 1'b1, 3'd0);
        step();
        step();
        step();
        chk3("abort_idx3", 8'hF7, 1'b1, 3'd3);
        g1 = 1'b0;
        step();
        chk3("abort", 8'hFF, 1'b0, 3'd0);
        g1 = 1'b1;
        step();
        chk3("abort_hold", 8'hFF, 1'b0, 3'd0);
        req = 1'b1;
        step();
        chk3("restart", 8'hFE, 1'b1, 3'd0);
        step();
        chk3("restart1", 8'hFD, 1'b1, 3'd1);

        rst = 1'b1;
        step();
        chk3("midrst", 8'hFF, 1'b0, 3'd0);
        rst = 1'b0;
        step();
        chk3("rst_req_held1", 8'hFF, 1'b0, 3'd0);
        step();
        chk3("rst_req_held2", 8'hFF, 1'b0, 3'd0);
        req = 1'b0;
        step();
        chk3("rst_req_low", 8'hFF, 1'b0, 3'd0);
        req = 1'b1;
        step();
        chk3("rst_fresh_req", 8'hFE, 1'b1, 3'd0);
        req = 1'b0;
        g1 = 1'b0;
        step();
        chk3("final_abort", 8'hFF, 1'b0, 3'd0);

        g1b = 1'b1;
        sel2 = 4'd15;
        step();
        chk("w4_sel15.out", 32'(out2), 32'h8000);
        chk("w4_sel15.idx", 32'(idx2), 32'd15);
        sel2 = 4'd0;
        step();
        chk("w4_sel0.out", 32'(out2), 32'h0001);
        g1b = 1'b0;
        step();
        chk("w4_off.out", 32'(out2), 32'h0000);
        chk("w4_off.busy", 32'(busy2), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
